// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller: Moore sequencing FSM plus ALU decoder.
// Optional feature: define BNE_EN to decode bne (000101) through the BRANCH state.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic [2:0] ALUControl,
   output logic       illegal_op
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
      ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] aluop;
   logic       pcwrite, branch, branch_cond;
   logic [2:0] funct_ctl;
   logic       funct_ok;
   logic       memwrite_s, irwrite_s, regwrite_s, illegal_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // R-type funct decode; an unknown funct falls back to ADD and is flagged
   always_comb begin
      funct_ctl = 3'b000;
      funct_ok  = 1'b1;
      case (funct)
         6'b100000: funct_ctl = 3'b000;
         6'b100010: funct_ctl = 3'b001;
         6'b100100: funct_ctl = 3'b010;
         6'b100101: funct_ctl = 3'b011;
         6'b101010: funct_ctl = 3'b100;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      case (aluop)
         2'b01:   ALUControl = 3'b001;
         2'b10:   ALUControl = funct_ctl;
         default: ALUControl = 3'b000;
      endcase
   end

`ifdef BNE_EN
   assign branch_cond = (opcode == OP_BNE) ? ~zero : zero;
`else
   assign branch_cond = zero;
`endif

   always_comb begin
      state_d    = FETCH;
      IorD       = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      regwrite_s = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      aluop      = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      illegal_s  = 1'b0;
      case (state_q)
         FETCH: begin
            irwrite_s = 1'b1;
            ALUSrcB   = 2'b01;
            pcwrite   = 1'b1;
            state_d   = DECODE;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
`ifdef BNE_EN
               OP_BNE:       state_d = BRANCH;
`endif
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default:      illegal_s = 1'b1;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            IorD    = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            MemtoReg   = 1'b1;
            regwrite_s = 1'b1;
         end
         MEMWR: begin
            IorD       = 1'b1;
            memwrite_s = 1'b1;
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            aluop   = 2'b10;
            if (funct_ok) state_d = ALUWB;
            else          illegal_s = 1'b1;
         end
         ALUWB: begin
            RegDst     = 1'b1;
            regwrite_s = 1'b1;
         end
         BRANCH: begin
            ALUSrcA = 1'b1;
            aluop   = 2'b01;
            PCSrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = ADDIWB;
         end
         ADDIWB: regwrite_s = 1'b1;
         JUMP: begin
            PCSrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // Reset wins combinationally so no write or PC load leaks while it is held
   assign MemWrite   = memwrite_s & ~reset;
   assign IRWrite    = irwrite_s  & ~reset;
   assign RegWrite   = regwrite_s & ~reset;
   assign PCEn       = (pcwrite | (branch & branch_cond)) & ~reset;
   assign illegal_op = illegal_s  & ~reset;

endmodule
